// File: rtl/audio_fifo_bank.sv
// Multi-channel PCM sample FIFO bank behind an APB3 slave. All channels pop together
// on each DSP sample tick; watermark IRQ, underrun counting and overflow flagging.
module audio_fifo_bank #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [31:0]                  PADDR,
  input  logic [31:0]                  PWDATA,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic                         req_in,
  output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
  output logic                         tick_out,
  output logic                         play_out,
  output logic                         irq_out
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

  logic        access, apb_err, apb_ok, mapped;
  logic [4:0]  idx;
  logic        cmd_wr, cmd_clr, cmd_start, cmd_stop, cmd_ack, tick;
  logic        play_reg, play_next;
  logic        irq_reg, irq_next;
  logic        req_reg;
  logic        underrun_reg, underrun_next;
  logic        overflow_reg, overflow_next;
  logic [8:0]  thresh_reg, thresh_next;
  logic [15:0] urun_cnt_reg, urun_cnt_next;
  logic [31:0] rd_data;

  logic [CHANNELS-1:0] ch_sel, empty_vec, below_vec, ovf_vec;
  logic [8:0]          fill_ext [CHANNELS];
  logic [SAMPLE_W-1:0] head_arr [CHANNELS];

  assign idx     = PADDR[6:2];
  assign access  = PSEL & PENABLE;
  assign mapped  = (idx < 5'(4 + CHANNELS));
  assign apb_err = access & (~mapped
                             | (PWRITE & ((idx == 5'd1) | (idx == 5'd3)))
                             | (~PWRITE & (idx == 5'd0)));
  assign apb_ok  = access & ~apb_err;

  assign cmd_wr    = apb_ok & PWRITE & (idx == 5'd0);
  assign cmd_clr   = cmd_wr & (PWDATA == 32'd1) & ~play_reg;
  assign cmd_start = cmd_wr & (PWDATA == 32'd2);
  assign cmd_stop  = cmd_wr & (PWDATA == 32'd3);
  assign cmd_ack   = cmd_wr & (PWDATA == 32'd4);
  assign tick      = req_reg;

  // The head sample must be visible combinationally, so each channel is a register array.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_reg, wr_ptr_reg;
    logic [FILL_W-1:0]   fill_reg, fill_next;
    logic                push, push_ok, pop, empty, full;

    assign ch_sel[gi]    = (idx == 5'(4 + gi));
    assign empty         = (fill_reg == '0);
    assign full          = (fill_reg == FULL_LVL);
    assign push          = apb_ok & PWRITE & ch_sel[gi];
    assign push_ok       = push & ~full;
    assign pop           = ~empty & (tick | (apb_ok & ~PWRITE & ch_sel[gi]));
    assign ovf_vec[gi]   = push & full;
    assign empty_vec[gi] = empty;

    always_comb begin
      fill_next = fill_reg;
      if (push_ok & ~pop)
        fill_next = fill_reg + 1'b1;
      else if (~push_ok & pop)
        fill_next = fill_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fill_reg   <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else if (cmd_clr) begin
        fill_reg   <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        fill_reg <= fill_next;
        if (push_ok)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok)
        mem[wr_ptr_reg] <= PWDATA[SAMPLE_W-1:0];
    end

    assign head_arr[gi] = empty ? '0 : mem[rd_ptr_reg];
    assign audio_out[gi*SAMPLE_W +: SAMPLE_W] = head_arr[gi];
    assign fill_ext[gi]  = 9'(fill_reg);
    assign below_vec[gi] = (fill_ext[gi] <= thresh_reg);
  end

  always_comb begin
    play_next = play_reg;
    if (cmd_start)
      play_next = 1'b1;
    else if (cmd_stop)
      play_next = 1'b0;

    // Acknowledge and stop beat a simultaneous set; the set re-fires next cycle if still due.
    irq_next = irq_reg;
    if (cmd_stop | cmd_ack)
      irq_next = 1'b0;
    else if (play_reg & (&below_vec))
      irq_next = 1'b1;

    thresh_next = thresh_reg;
    if (apb_ok & PWRITE & (idx == 5'd2))
      thresh_next = PWDATA[8:0];

    underrun_next = underrun_reg;
    urun_cnt_next = urun_cnt_reg;
    overflow_next = overflow_reg | (|ovf_vec);
    if (tick & (|empty_vec)) begin
      underrun_next = 1'b1;
      if (urun_cnt_reg != 16'hFFFF)
        urun_cnt_next = urun_cnt_reg + 16'd1;
    end
    if (cmd_clr) begin
      underrun_next = 1'b0;
      overflow_next = 1'b0;
      urun_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_reg     <= 1'b0;
      irq_reg      <= 1'b0;
      req_reg      <= 1'b0;
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      thresh_reg   <= '0;
      urun_cnt_reg <= '0;
    end else begin
      play_reg     <= play_next;
      irq_reg      <= irq_next;
      req_reg      <= req_in & play_reg;
      underrun_reg <= underrun_next;
      overflow_reg <= overflow_next;
      thresh_reg   <= thresh_next;
      urun_cnt_reg <= urun_cnt_next;
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      5'd1:    rd_data = {16'h0, fill_ext[0][7:0], 4'h0,
                          irq_reg, overflow_reg, underrun_reg, play_reg};
      5'd2:    rd_data = {23'h0, thresh_reg};
      5'd3:    rd_data = {16'h0, urun_cnt_reg};
      default: begin
        for (int c = 0; c < CHANNELS; c++)
          if (ch_sel[c])
            rd_data = 32'(head_arr[c]);
      end
    endcase
  end

  assign PRDATA   = (apb_ok & ~PWRITE) ? rd_data : '0;
  assign PREADY   = 1'b1;
  assign PSLVERR  = apb_err;
  assign tick_out = req_reg;
  assign play_out = play_reg;
  assign irq_out  = irq_reg;

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:7], PADDR[1:0], fill_ext[0][8]};
endmodule

// File: doc/audio_fifo_bank.md
# audio_fifo_bank

Parametrised multi-channel audio sample buffer with an APB3 slave port, for the audioport datapath. Software writes PCM samples into per-channel FIFOs and controls playback by command. On each accepted sample request all channels pop together and present their head samples to the DSP. Adds watermark interrupt, underrun counting, overflow flagging and APB error responses.

## Interface
- CHANNELS, 2: number of audio channels (1..8)
- DEPTH, 16: samples per channel FIFO (power of two, 4..256)
- SAMPLE_W, 24: sample width in bits (8..32)
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PADDR  in  32  byte address; word index = PADDR[6:2], PADDR[1:0] ignored
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  constant 1
- PSLVERR  out  1  error response
- req_in  in  1  sample request from the DSP clock domain (already synchronised)
- audio_out  out  CHANNELS*SAMPLE_W  head sample of each channel; channel c at [c*SAMPLE_W +: SAMPLE_W]
- tick_out  out  1  one-cycle pulse for each accepted sample request
- play_out  out  1  playback active
- irq_out  out  1  watermark interrupt

## Operation
- Access phase = PSEL & PENABLE. Write = access & PWRITE. Read = access & !PWRITE.
- Word index 0, CMD (WO; reads return 0). Write values:
  - 1 = CLR: empties all FIFOs, clears STATUS sticky bits and UNDERRUN. Ignored while playing.
  - 2 = START: play=1.
  - 3 = STOP: play=0 and irq=0.
  - 4 = IRQACK: irq=0.
  - Any other value: no effect.
- Index 1, STATUS (RO):
  - [0] play
  - [1] underrun (sticky)
  - [2] overflow (sticky)
  - [3] irq
  - [15:8] fill of channel 0
- Index 2, THRESH (RW): reset 0. Bits [8:0] are significant; the rest read back 0.
- Index 3, UNDERRUN (RO): 16-bit saturating count. Cleared only by CLR.
- Index 4+c, c < CHANNELS, channel c FIFO:
  - Write pushes PWDATA[SAMPLE_W-1:0].
  - Read returns the zero-extended head sample and pops it. If the FIFO is empty, the read returns 0 and does not pop.
- PSLVERR = access & (unmapped index, or a write to index 1, 3, or a read of index 0). An erroring access has no side effect.
- Each channel holds a fill counter (0..DEPTH), a read pointer and a write pointer. Both pointers wrap at DEPTH.
- Push to a full FIFO: sample is dropped and the overflow bit is set. Full is judged on the registered fill, even if a pop occurs in the same cycle.
- Push and pop in the same cycle on a non-full FIFO: both occur and fill is unchanged.
- req_r <= req_in & play. A cycle with req_r=1 is a tick:
  - All channels pop simultaneously.
  - Empty channels do not pop and output 0.
  - If any channel is empty, UNDERRUN increments once (saturating at 16'hFFFF) and the underrun bit sets.
- A tick pop and an APB pop of the same channel in the same cycle count as a single pop.
- audio_out for channel c is the head sample when fill_c > 0, else 0.
- irq is set when play=1 and every channel's fill <= THRESH.
  - IRQACK or STOP in the same cycle wins over set.
  - While the condition persists, irq re-asserts the cycle after an IRQACK.
- If START and STOP are both pending, only one can be written per access, so no conflict exists.

## Timing
- Reset values: PRDATA=0, PSLVERR=0, PREADY=1, audio_out=0, tick_out=0, play_out=0, irq_out=0. All FIFOs empty, registers 0.
- APB has zero wait states. PRDATA is combinational from the registered state during the access phase and 0 when PSEL=0.
- Register, FIFO and command effects become visible on the clock edge that ends the access phase.
- req_in to tick_out: 1 cycle (tick_out = req_r). The pop and the new audio_out are visible the cycle after the tick.
- irq_out is registered and rises 1 cycle after the condition becomes true.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). Samples are not preserved.

## Test plan
- **Reset / error:** assert rst_n low during playback → all outputs 0 immediately. Read index 31 → PSLVERR=1, PRDATA=0. Write STATUS → PSLVERR=1, register unchanged.
- **Wrap-around:** with CHANNELS=2, DEPTH=4, push 6 samples 0x1..0x6 to channel 0 → overflow=1, fill=4. APB reads return 1,2,3,4, then 0. Then push 0xA,0xB → pointers wrap and reads return A,B.
- **Playback:** push 3 samples to each channel, START, hold req_in=1 for 4 cycles → 4 tick_out pulses. audio_out steps through the samples, then reads 0. UNDERRUN=1, underrun bit=1.
- **Watermark:** THRESH=2, fill both channels to 4, START, pulse req_in twice → irq_out rises 1 cycle after both fills reach 2. IRQACK → irq_out drops, then re-asserts 1 cycle later. STOP → irq_out=0 and stays 0.
- **CLR gating:** CLR while playing → FIFOs unchanged. STOP then CLR → fills 0, UNDERRUN 0, sticky bits 0.
- **Simultaneous access:** APB push to a channel with fill 2 in the same cycle as a tick → fill stays 2 and the head advances. APB pop in the same cycle as a tick → only one sample is removed.
